uart_rx_frontend: RTL and testbench

// - Fabric-side UART receiver for the SoC's uart2_txd line, i.e. the far end of the CPU UART2 link.
// - Deserialises 8N1 frames at 16x oversampling and buffers bytes in a small FIFO.
// - Hands bytes to fabric logic (console capture, boot/debug monitor) over a valid/ready handshake.
// - Runs in the 100 MHz fabric clock domain and sits beside the SoC CPU in the top level.

---
 rtl/uart_pkg.sv | 30 +++
 rtl/sync_fifo.sv | 56 +++++
 rtl/uart_rx_frontend.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the fabric-side UART receive path.
//   rx_state_t  : receiver FSM state encoding
//   OVERSAMPLE  : ticks per serial bit
//   SAMPLE_*    : sub-bit tick indices used for the three-sample majority vote
//   maj3()      : 2-of-3 majority helper
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  localparam int OVERSAMPLE = 16;

  // Samples straddle the bit centre; the vote resolves on the last of them.
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_MID = 8;
  localparam int SAMPLE_HI  = 9;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock show-ahead FIFO. rdata is the head entry, read combinationally
// from the storage array, so it is stable while nothing is popped.
//   clk_i, rst_i : clock, synchronous active-high reset
//   push, wdata  : write request and data
//   pop          : read request (advances the head)
//   rdata        : head-of-queue entry
//   full, empty  : occupancy flags
// A pop in the same cycle frees a slot, so push while full-and-popping is
// accepted. A pop while empty is ignored even if a push lands that cycle.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]                  wr_ptr, rd_ptr;
  logic [DEPTH-1:0][WIDTH-1:0]  mem;
  logic                         do_push, do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// uart_rx_frontend
// Fabric-side 8N1 UART receiver with 16x oversampling and a small show-ahead
// receive FIFO, handing bytes out over a valid/ready handshake.
//   clk_i        : fabric clock (rising edge)
//   rst_i        : synchronous active-high reset
//   rxd_i        : asynchronous serial input, idles high
//   rx_data_o    : head-of-FIFO byte, valid while rx_valid_o = 1
//   rx_valid_o   : FIFO not empty
//   rx_ready_i   : consumer accept; pops on rx_valid_o & rx_ready_i
//   frame_err_o  : one-cycle pulse, stop bit voted low
//   overrun_o    : one-cycle pulse, byte completed with the FIFO full
//   busy_o       : receiver FSM not idle
// ---------------------------------------------------------------------------
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int BAUD_DIV   = 54,
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  input  logic                 rx_ready_i,
  output logic                 frame_err_o,
  output logic                 overrun_o,
  output logic                 busy_o
);

  localparam int CW  = (BAUD_DIV > 1)  ? $clog2(BAUD_DIV)  : 1;
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam int SCW = $clog2(OVERSAMPLE);

  localparam logic [CW-1:0]  CNT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_BITS - 1);
  localparam logic [SCW-1:0] SC_LO    = SCW'(SAMPLE_LO);
  localparam logic [SCW-1:0] SC_MID   = SCW'(SAMPLE_MID);
  localparam logic [SCW-1:0] SC_HI    = SCW'(SAMPLE_HI);
  localparam logic [SCW-1:0] SC_LAST  = SCW'(OVERSAMPLE - 1);

  // synchroniser
  logic rxd_meta, rxs;

  // baud tick generation
  logic [CW-1:0] tick_cnt;
  logic          tick;

  // receiver FSM and datapath
  rx_state_t              state, state_nxt;
  logic [SCW-1:0]         sc;
  logic [BW-1:0]          bit_idx;
  logic [DATA_BITS-1:0]   shift_q;
  logic [1:0]             samp_q;   // [0] = sample at SAMPLE_LO, [1] = at SAMPLE_MID
  logic                   vote;
  logic                   start_det, at_vote, at_end;

  // FIFO side
  logic push_c, ferr_c, ovr_c;
  logic pop, full, empty;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser, preset high so reset never looks like a start bit.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rxd_meta <= 1'b1;
      rxs      <= 1'b1;
    end else begin
      rxd_meta <= rxd_i;
      rxs      <= rxd_meta;
    end
  end

  // -------------------------------------------------------------------------
  // Tick counter. Restarting it on the start edge phase-aligns every
  // following tick to that edge, so sub-bit indices map to fixed bit offsets.
  // -------------------------------------------------------------------------
  assign start_det = (state == IDLE) && !rxs;
  assign tick      = (tick_cnt == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i || start_det || tick) tick_cnt <= '0;
    else                            tick_cnt <= tick_cnt + 1'b1;
  end

  // The third sample is the live line value on the SAMPLE_HI tick.
  assign vote    = maj3(samp_q[0], samp_q[1], rxs);
  assign at_vote = tick && (sc == SC_HI);
  assign at_end  = tick && (sc == SC_LAST);

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  // -------------------------------------------------------------------------
  // FSM next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (!rxs) state_nxt = START;
      START: begin
        if (at_vote && vote) state_nxt = IDLE;     // too short to be a start bit
        else if (at_end)     state_nxt = DATA;
      end
      DATA:  if (at_end && (bit_idx == BIT_LAST)) state_nxt = STOP;
      STOP:  if (at_vote) state_nxt = vote ? IDLE : BREAK;
      // sc counts consecutive high ticks here; any low sample restarts it.
      BREAK: if (tick && rxs && (sc == SC_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs
  // -------------------------------------------------------------------------
  always_comb begin
    push_c = 1'b0;
    ferr_c = 1'b0;
    busy_o = 1'b1;
    case (state)
      IDLE: busy_o = 1'b0;
      STOP: begin
        if (at_vote) begin
          push_c = vote;
          ferr_c = !vote;
        end
      end
      default: ;
    endcase
  end

  // A pop coinciding with the push frees the slot, so that is not an overrun.
  assign ovr_c = push_c & full & ~pop;

  // -------------------------------------------------------------------------
  // Sub-bit counter, sample capture and shift register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc      <= '0;
      bit_idx <= '0;
      shift_q <= '0;
      samp_q  <= '0;
    end else begin
      if (tick && (sc == SC_LO))  samp_q[0] <= rxs;
      if (tick && (sc == SC_MID)) samp_q[1] <= rxs;

      case (state)
        IDLE: begin
          sc      <= '0;
          bit_idx <= '0;
        end
        BREAK: begin
          if (!rxs)      sc <= '0;
          else if (tick) sc <= sc + 1'b1;
        end
        default: if (tick) sc <= sc + 1'b1;
      endcase

      if ((state == DATA) && at_vote) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
      if ((state == DATA) && at_end)  bit_idx <= bit_idx + 1'b1;

      // BREAK reuses sc as its high-run counter, so start it from zero.
      if ((state == STOP) && at_vote) sc <= '0;
    end
  end

  // Pulses are registered so they line up with the registered FIFO push.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= ferr_c;
      overrun_o   <= ovr_c;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FIFO
  // -------------------------------------------------------------------------
  assign rx_valid_o = ~empty;
  assign pop        = rx_valid_o & rx_ready_i;

  sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_c),
    .wdata (shift_q),
    .pop   (pop),
    .rdata (rx_data_o),
    .full  (full),
    .empty (empty)
  );

endmodule

// File: tb/tb_uart_rx_frontend.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frontend
// Drives serial frames into uart_rx_frontend and compares received bytes,
// error pulses and handshake timing against expectations derived from the
// frame contents and a queue model of the receive FIFO.
// ---------------------------------------------------------------------------
module tb_uart_rx_frontend;

  localparam int BD      = 4;
  localparam int DW      = 8;
  localparam int DEPTH   = 4;
  localparam int BIT_CLK = 16 * BD;
  // Start edge -> rx_valid: 2 sync flops + 1 detect edge, then the stop bit's
  // sc=9 tick ends (16*(DW+1) + 10) ticks after the counter restart.
  localparam int LAT     = 3 + BD * (16 * (DW + 1) + 10);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rxd = 1'b1;
  logic          ready = 1'b1;
  logic [DW-1:0] rx_data;
  logic          rx_valid, ferr, ovr, busy;

  int checks = 0, failures = 0;
  int cyc = 0, ferr_cnt = 0, ovr_cnt = 0;
  int got_q[$], got_cyc_q[$], start_q[$], exp_q[$];
  bit rnd_rdy = 1'b0;

  uart_rx_frontend #(
    .BAUD_DIV   (BD),
    .DATA_BITS  (DW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .rxd_i       (rxd),
    .rx_data_o   (rx_data),
    .rx_valid_o  (rx_valid),
    .rx_ready_i  (ready),
    .frame_err_o (ferr),
    .overrun_o   (ovr),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer monitor: samples on the falling edge, away from input drives.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid && ready) begin
        got_q.push_back(int'(rx_data));
        got_cyc_q.push_back(cyc);
      end
      if (ferr) ferr_cnt++;
      if (ovr)  ovr_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rnd_rdy) begin
      #1;
      ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear();
    got_q.delete();
    got_cyc_q.delete();
    start_q.delete();
    exp_q.delete();
    ferr_cnt = 0;
    ovr_cnt  = 0;
  endtask

  task automatic send(input logic [DW-1:0] b, input int bc, input logic stop_v);
    @(posedge clk); #1;
    start_q.push_back(cyc);
    rxd = 1'b0;
    repeat (bc) @(posedge clk); #1;
    for (int i = 0; i < DW; i++) begin
      rxd = b[i];
      repeat (bc) @(posedge clk); #1;
    end
    rxd = stop_v;
    repeat (bc) @(posedge clk); #1;
    rxd = 1'b1;
  endtask

  task automatic cmp_bytes(input string tag);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
  endtask

  initial begin
    int mq[$];
    int exp_ovr;
    logic [DW-1:0] b;

    // ---------------- reset state ----------------
    idle(5);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_data",  int'(rx_data),  0);
    chk("rst_busy",  int'(busy),     0);
    chk("rst_ferr",  int'(ferr),     0);
    chk("rst_ovr",   int'(ovr),      0);
    rst = 1'b0;
    idle(20);

    // ---------------- reset mid-frame ----------------
    clear();
    b = 8'h55;
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (BIT_CLK) @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      repeat (BIT_CLK) @(posedge clk); #1;
    end
    chk("midframe_busy", int'(busy), 1);
    rst = 1'b1;
    rxd = 1'b1;
    idle(3);
    chk("midrst_busy", int'(busy), 0);
    rst = 1'b0;
    idle(50);
    exp_q.push_back(8'hA3);
    send(8'hA3, BIT_CLK, 1'b1);
    idle(40);
    cmp_bytes("rstfrm");
    chk("rstfrm_ferr", ferr_cnt, 0);
    chk("rstfrm_ovr",  ovr_cnt,  0);

    // ---------------- basic back-to-back ----------------
    clear();
    ready = 1'b1;
    exp_q = '{8'h00, 8'hFF, 8'h5A, 8'h81};
    foreach (exp_q[i]) send(exp_q[i][DW-1:0], BIT_CLK, 1'b1);
    idle(40);
    cmp_bytes("basic");
    for (int i = 0; i < 4 && i < got_cyc_q.size() && i < start_q.size(); i++)
      chk($sformatf("basic_lat%0d", i), got_cyc_q[i] - start_q[i], LAT);
    chk("basic_ferr", ferr_cnt, 0);

    // ---------------- random bytes, random gaps, random ready ----------------
    clear();
    rnd_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      exp_q.push_back(int'(b));
      send(b, BIT_CLK, 1'b1);
      idle($urandom_range(0, 40));
    end
    idle(40);
    rnd_rdy = 1'b0;
    @(posedge clk); #1;
    ready = 1'b1;
    idle(10);
    cmp_bytes("rand");
    chk("rand_ferr", ferr_cnt, 0);
    chk("rand_ovr",  ovr_cnt,  0);

    // ---------------- overrun ----------------
    clear();
    ready = 1'b0;
    mq.delete();
    exp_ovr = 0;
    for (int i = 0; i < 6; i++) begin
      send(8'(8'h10 + i), BIT_CLK, 1'b1);
      if (mq.size() < DEPTH) mq.push_back(8'h10 + i);
      else                   exp_ovr++;
    end
    idle(20);
    chk("ovr_pulses",   ovr_cnt,         exp_ovr);
    chk("ovr_nopop",    got_q.size(),    0);
    chk("ovr_valid",    int'(rx_valid),  1);
    chk("ovr_head",     int'(rx_data),   mq[0]);
    ready = 1'b1;
    idle(10);
    exp_q = mq;
    cmp_bytes("ovr_drain");
    chk("ovr_valid_after", int'(rx_valid), 0);

    // ---------------- simultaneous push and pop while full ----------------
    clear();
    ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'(8'h20 + i), BIT_CLK, 1'b1);
    fork
      send(8'h24, BIT_CLK, 1'b1);
      begin
        @(posedge clk); #1;
        repeat (LAT - 1) @(posedge clk); #1;
        ready = 1'b1;
        @(posedge clk); #1;
        ready = 1'b0;
      end
    join
    idle(20);
    chk("simul_ovr",    ovr_cnt,        0);
    chk("simul_popped", got_q.size(),   1);
    chk("simul_head",   int'(rx_data),  8'h21);
    ready = 1'b1;
    idle(10);
    exp_q = '{8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
    cmp_bytes("simul");

    // ---------------- glitch on idle line ----------------
    clear();
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (BD) @(posedge clk); #1;
    rxd = 1'b1;
    idle(10);
    chk("glitch_busy_hi", int'(busy), 1);
    idle(150);
    chk("glitch_busy_lo", int'(busy), 0);
    chk("glitch_nobyte",  got_q.size(), 0);
    chk("glitch_ferr",    ferr_cnt, 0);

    // ---------------- framing error ----------------
    clear();
    send(8'h3C, BIT_CLK, 1'b0);
    idle(150);
    chk("frm_ferr",   ferr_cnt, 1);
    chk("frm_nobyte", got_q.size(), 0);
    chk("frm_busy",   int'(busy), 0);

    // ---------------- line held low (break) then recovery ----------------
    clear();
    @(posedge clk); #1;
    rxd = 1'b0;
    repeat (3 * 10 * BIT_CLK) @(posedge clk); #1;
    chk("brk_busy_hi", int'(busy), 1);
    rxd = 1'b1;
    idle(150);
    chk("brk_ferr",  ferr_cnt, 1);
    chk("brk_busy",  int'(busy), 0);
    exp_q.push_back(8'h7E);
    send(8'h7E, BIT_CLK, 1'b1);
    idle(40);
    cmp_bytes("brk_recover");
    chk("brk_ferr_after", ferr_cnt, 1);

    // ---------------- baud tolerance ----------------
    clear();
    exp_q = '{8'hC5, 8'hC5};
    send(8'hC5, 66, 1'b1);
    idle(40);
    send(8'hC5, 62, 1'b1);
    idle(40);
    cmp_bytes("tol");
    chk("tol_ferr", ferr_cnt, 0);
    chk("tol_ovr",  ovr_cnt,  0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
